instruction_fetch_unit: RTL and testbench

Fetch stage directly downstream of the program counter. It takes the current PC value, runs a req/ack read handshake with instruction memory, and latches the returned word into a single-entry instruction register for the decode stage. After each successful fetch it pulses pc_write so the PC advances. On a taken-branch flush it discards in-flight or buffered instructions and refetches from the redirected PC.

---
 rtl/instruction_fetch_unit.sv | 115 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC -> imem req/ack handshake -> single-entry instruction register for decode.
// Latency: REQ on the cycle after leaving IDLE/HOLD; IR valid the cycle after ack; 3 cycles/instr at zero-wait.
// Backpressure: a held IR blocks the next fetch until decode takes it; memory wait cycles are unbounded.
module instruction_fetch_unit #(
   parameter int ADDR_W  = 12,
   parameter int INSTR_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [ADDR_W-1:0]  pc_in,
   input  logic               halt,
   input  logic               flush,
   output logic               pc_write,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] ir_out,
   output logic [ADDR_W-1:0]  ir_pc,
   output logic               ir_valid,
   input  logic               ir_ready
);

   typedef enum logic [1:0] {IDLE, REQ, HOLD, DISCARD} state_t;

   state_t               state_q, state_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [INSTR_W-1:0]   ir_q, ir_d;
   logic [ADDR_W-1:0]    ir_pc_q, ir_pc_d;
   logic                 ir_valid_q, ir_valid_d;
   logic                 pc_write_q, pc_write_d;

   // Next-state logic: handshake sequencing, IR capture/consume, flush handling.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      ir_d       = ir_q;
      ir_pc_d    = ir_pc_q;
      ir_valid_d = ir_valid_q;
      pc_write_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (flush) begin
               ir_valid_d = 1'b0;
            end else if (!halt) begin
               state_d = REQ;
               addr_d  = pc_in;
            end
         end
         REQ: begin
            if (imem_ack && !flush) begin
               ir_d       = imem_rdata;
               ir_pc_d    = addr_q;
               ir_valid_d = 1'b1;
               pc_write_d = 1'b1;
               state_d    = HOLD;
            end else if (imem_ack) begin
               // Redirect arrived with the data: the word belongs to the old path.
               state_d = IDLE;
            end else if (flush) begin
               // The memory still owes us an ack; swallow it before refetching.
               state_d = DISCARD;
            end
         end
         DISCARD: begin
            if (imem_ack) begin
               state_d = IDLE;
            end
         end
         HOLD: begin
            if (flush) begin
               ir_valid_d = 1'b0;
               state_d    = IDLE;
            end else begin
               if (ir_valid_q && ir_ready) begin
                  ir_valid_d = 1'b0;
               end
               // Waiting out the pc_write cycle guarantees pc_in already holds the next PC.
               if ((!ir_valid_q || ir_ready) && !pc_write_q && !halt) begin
                  state_d = REQ;
                  addr_d  = pc_in;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset wins over every other input.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         ir_q       <= '0;
         ir_pc_q    <= '0;
         ir_valid_q <= 1'b0;
         pc_write_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         ir_q       <= ir_d;
         ir_pc_q    <= ir_pc_d;
         ir_valid_q <= ir_valid_d;
         pc_write_q <= pc_write_d;
      end
   end

   assign imem_req  = (state_q == REQ) || (state_q == DISCARD);
   assign imem_addr = addr_q;
   assign ir_out    = ir_q;
   assign ir_pc     = ir_pc_q;
   assign ir_valid  = ir_valid_q;
   assign pc_write  = pc_write_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: per-cycle vector table plus a zero-wait streaming sequence.
// Inputs change on the falling edge; outputs are checked 1ns after the rising edge.
// Memory and decode are modelled by the bench; every expected value is hand-derived.
module tb_instruction_fetch_unit;

   logic        clk = 1'b0;
   logic        reset, halt, flush, imem_ack, ir_ready;
   logic [11:0] pc_in;
   logic [15:0] imem_rdata;
   logic        pc_write, imem_req, ir_valid;
   logic [11:0] imem_addr, ir_pc;
   logic [15:0] ir_out;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   instruction_fetch_unit #(.ADDR_W(12), .INSTR_W(16)) dut (
      .clk(clk), .reset(reset), .pc_in(pc_in), .halt(halt), .flush(flush),
      .pc_write(pc_write), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .ir_out(ir_out), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready)
   );

   typedef struct {
      logic        rst;
      logic [11:0] pc;
      logic        hlt, fl, ack;
      logic [15:0] rd;
      logic        rdy;
      logic        e_pw, e_req;
      logic [11:0] e_addr;
      logic [15:0] e_ir;
      logic [11:0] e_irpc;
      logic        e_v;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic rst, input logic [11:0] pc, input logic hlt, input logic fl,
                      input logic ack, input logic [15:0] rd, input logic rdy,
                      input logic e_pw, input logic e_req, input logic [11:0] e_addr,
                      input logic [15:0] e_ir, input logic [11:0] e_irpc, input logic e_v);
      vec_t v;
      v.rst = rst; v.pc = pc; v.hlt = hlt; v.fl = fl; v.ack = ack; v.rd = rd; v.rdy = rdy;
      v.e_pw = e_pw; v.e_req = e_req; v.e_addr = e_addr; v.e_ir = e_ir; v.e_irpc = e_irpc; v.e_v = e_v;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   initial begin
      int          pc_model, exp_addr, fetches, cycles, last_pw, prev_pw;

      reset = 1'b1; pc_in = '0; halt = 1'b0; flush = 1'b0;
      imem_ack = 1'b0; imem_rdata = '0; ir_ready = 1'b1;

      //   rst pc     h  f  ack rdata    rdy  pw req addr    ir       irpc    v
      add(1, 12'h000, 0, 0, 0, 16'h0000, 1,   0, 0, 12'h000, 16'h0000, 12'h000, 0); // reset
      add(0, 12'h000, 0, 0, 0, 16'h0000, 1,   0, 1, 12'h000, 16'h0000, 12'h000, 0); // IDLE->REQ
      add(0, 12'h000, 0, 0, 1, 16'hA5C3, 1,   1, 0, 12'h000, 16'hA5C3, 12'h000, 1); // ack
      add(0, 12'h000, 0, 0, 0, 16'h0000, 1,   0, 0, 12'h000, 16'hA5C3, 12'h000, 0); // pc_write cycle
      add(0, 12'h001, 0, 0, 0, 16'h0000, 1,   0, 1, 12'h001, 16'hA5C3, 12'h000, 0);
      add(0, 12'h001, 0, 0, 1, 16'h1111, 1,   1, 0, 12'h001, 16'h1111, 12'h001, 1);
      add(0, 12'h001, 0, 0, 0, 16'h0000, 1,   0, 0, 12'h001, 16'h1111, 12'h001, 0);
      add(0, 12'h002, 0, 0, 0, 16'h0000, 1,   0, 1, 12'h002, 16'h1111, 12'h001, 0);
      add(0, 12'h002, 0, 0, 1, 16'h2222, 1,   1, 0, 12'h002, 16'h2222, 12'h002, 1);
      // decode stalls for 5 cycles
      add(0, 12'h002, 0, 0, 0, 16'h0000, 0,   0, 0, 12'h002, 16'h2222, 12'h002, 1);
      for (int i = 0; i < 4; i++)
         add(0, 12'h003, 0, 0, 0, 16'h0000, 0, 0, 0, 12'h002, 16'h2222, 12'h002, 1);
      add(0, 12'h003, 0, 0, 0, 16'h0000, 1,   0, 1, 12'h003, 16'h2222, 12'h002, 0); // resume
      add(0, 12'h003, 0, 0, 1, 16'h3333, 1,   1, 0, 12'h003, 16'h3333, 12'h003, 1);
      add(0, 12'h003, 0, 0, 0, 16'h0000, 1,   0, 0, 12'h003, 16'h3333, 12'h003, 0);
      // 4 wait cycles at 0x010, pc_in wanders meanwhile
      add(0, 12'h010, 0, 0, 0, 16'h0000, 1,   0, 1, 12'h010, 16'h3333, 12'h003, 0);
      for (int i = 0; i < 4; i++)
         add(0, 12'h055, 0, 0, 0, 16'h0000, 1, 0, 1, 12'h010, 16'h3333, 12'h003, 0);
      add(0, 12'h055, 0, 0, 1, 16'h4444, 1,   1, 0, 12'h010, 16'h4444, 12'h010, 1);
      add(0, 12'h011, 0, 0, 0, 16'h0000, 1,   0, 0, 12'h010, 16'h4444, 12'h010, 0);
      // flush while waiting at 0x020, second flush in DISCARD ignored
      add(0, 12'h020, 0, 0, 0, 16'h0000, 1,   0, 1, 12'h020, 16'h4444, 12'h010, 0);
      add(0, 12'h020, 0, 0, 0, 16'h0000, 1,   0, 1, 12'h020, 16'h4444, 12'h010, 0);
      add(0, 12'h020, 0, 1, 0, 16'h0000, 1,   0, 1, 12'h020, 16'h4444, 12'h010, 0);
      add(0, 12'h100, 0, 0, 0, 16'h0000, 1,   0, 1, 12'h020, 16'h4444, 12'h010, 0);
      add(0, 12'h100, 0, 1, 0, 16'h0000, 1,   0, 1, 12'h020, 16'h4444, 12'h010, 0);
      add(0, 12'h100, 0, 0, 1, 16'hDEAD, 1,   0, 0, 12'h020, 16'h4444, 12'h010, 0); // dropped
      add(0, 12'h100, 0, 0, 0, 16'h0000, 1,   0, 1, 12'h100, 16'h4444, 12'h010, 0); // refetch 0x100
      add(0, 12'h100, 0, 1, 1, 16'hBEEF, 1,   0, 0, 12'h100, 16'h4444, 12'h010, 0); // flush+ack
      add(0, 12'h100, 1, 0, 0, 16'h0000, 1,   0, 0, 12'h100, 16'h4444, 12'h010, 0); // halted
      add(0, 12'h100, 0, 0, 0, 16'h0000, 1,   0, 1, 12'h100, 16'h4444, 12'h010, 0);
      add(0, 12'h100, 0, 0, 0, 16'h0000, 1,   0, 1, 12'h100, 16'h4444, 12'h010, 0);
      add(1, 12'h100, 0, 0, 1, 16'h7777, 1,   0, 0, 12'h000, 16'h0000, 12'h000, 0); // reset mid-REQ
      add(0, 12'h200, 1, 0, 0, 16'h0000, 1,   0, 0, 12'h000, 16'h0000, 12'h000, 0);
      add(0, 12'h200, 0, 0, 0, 16'h0000, 1,   0, 1, 12'h200, 16'h0000, 12'h000, 0);
      add(0, 12'h200, 0, 0, 1, 16'h5555, 0,   1, 0, 12'h200, 16'h5555, 12'h200, 1);
      add(0, 12'h200, 0, 1, 0, 16'h0000, 0,   0, 0, 12'h200, 16'h5555, 12'h200, 0); // flush in HOLD
      add(0, 12'h201, 0, 0, 0, 16'h0000, 1,   0, 1, 12'h201, 16'h5555, 12'h200, 0);
      add(0, 12'h201, 0, 0, 1, 16'h6666, 0,   1, 0, 12'h201, 16'h6666, 12'h201, 1);
      add(0, 12'h201, 0, 0, 0, 16'h0000, 0,   0, 0, 12'h201, 16'h6666, 12'h201, 1);
      add(0, 12'h202, 1, 0, 0, 16'h0000, 0,   0, 0, 12'h201, 16'h6666, 12'h201, 1);
      add(0, 12'h202, 1, 0, 0, 16'h0000, 1,   0, 0, 12'h201, 16'h6666, 12'h201, 0); // halt holds
      add(0, 12'h202, 0, 0, 0, 16'h0000, 1,   0, 1, 12'h202, 16'h6666, 12'h201, 0);

      foreach (vq[i]) begin
         @(negedge clk);
         reset = vq[i].rst; pc_in = vq[i].pc; halt = vq[i].hlt; flush = vq[i].fl;
         imem_ack = vq[i].ack; imem_rdata = vq[i].rd; ir_ready = vq[i].rdy;
         @(posedge clk); #1;
         chk("pc_write",  i, 32'(pc_write),  32'(vq[i].e_pw));
         chk("imem_req",  i, 32'(imem_req),  32'(vq[i].e_req));
         chk("imem_addr", i, 32'(imem_addr), 32'(vq[i].e_addr));
         chk("ir_out",    i, 32'(ir_out),    32'(vq[i].e_ir));
         chk("ir_pc",     i, 32'(ir_pc),     32'(vq[i].e_irpc));
         chk("ir_valid",  i, 32'(ir_valid),  32'(vq[i].e_v));
      end

      // Streaming: PC advances on pc_write, memory acks immediately, decode always ready.
      @(negedge clk);
      reset = 1'b1; halt = 1'b0; flush = 1'b0; imem_ack = 1'b0; ir_ready = 1'b1; pc_in = '0;
      @(negedge clk);
      reset = 1'b0;
      pc_model = 0; exp_addr = 0; fetches = 0; cycles = 0; last_pw = -1; prev_pw = 0;
      while (fetches < 5 && cycles < 60) begin
         pc_in      = 12'(pc_model);
         imem_ack   = imem_req;
         imem_rdata = {4'hC, imem_addr};
         if (imem_req) begin
            chk("stream_addr", fetches, 32'(imem_addr), 32'(exp_addr));
            exp_addr++;
            fetches++;
         end
         if (pc_write) begin
            if (prev_pw == 1) chk("pw_double", cycles, 32'(pc_write), 32'd0);
            if (last_pw >= 0) chk("pw_interval", cycles, 32'(cycles - last_pw), 32'd3);
            chk("stream_ir", cycles, 32'(ir_out), 32'({4'hC, 12'(pc_model)}));
            last_pw = cycles;
            pc_model++;
         end
         prev_pw = int'(pc_write);
         cycles++;
         @(negedge clk);
      end
      imem_ack = 1'b0;
      chk("stream_done", cycles, 32'(fetches), 32'd5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
